// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer configuration sequencer slice.
//   - seq_state_t : sequencer FSM state encoding
//   - DIV_W       : width of the prescaler exponent (div_val)
//   - MAX_DIV_DEFAULT : largest legal exponent for an 8-bit prescaler counter
//   - clamp_div   : saturates a requested exponent to the legal maximum
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int DIV_W           = 4;
  localparam int MAX_DIV_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Oversized exponents saturate rather than wrap so software cannot
  // accidentally select a very short period with a bad write.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] req,
                                                 input logic [DIV_W-1:0] max_div);
    return (req > max_div) ? max_div : req;
  endfunction

endpackage

// File: rtl/timer_drain_wdog.sv
// ---------------------------------------------------------------------------
// timer_drain_wdog
// Loadable down-counter that bounds how long the sequencer waits for a
// prescaler tick before forcing a deferred configuration change through.
// Ports:
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   load             : load (1 << load_exp) + 2 into the counter
//   load_exp         : current prescaler exponent
//   run              : count down (asserted while the sequencer drains)
//   expire           : high during the last cycle of the wait window
// ---------------------------------------------------------------------------
module timer_drain_wdog
  import timer_pkg::*;
#(
  parameter int TO_W = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_exp,
  input  logic             run,
  output logic             expire
);

  logic [TO_W-1:0] count;

  // The counter holds the number of drain cycles still allowed, so the
  // window is exactly one full prescaler period plus two cycles of margin.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count <= '0;
    end else if (load) begin
      count <= (TO_W'(1) << load_exp) + TO_W'(2);
    end else if (run && (count != '0)) begin
      count <= count - TO_W'(1);
    end
  end

  assign expire = run && (count == TO_W'(1));

endmodule

// File: rtl/timer_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// timer_cfg_sequencer
// Sits in front of the timer prescaler control block. Software config writes
// are shadowed and applied to the prescaler inputs; a divisor change on a
// running divided timer is held back until the next prescaler tick so no
// partial period is produced. Also runs a req/ack debug-halt handshake.
// Ports:
//   sys_clk, sys_rst      : clock and synchronous active-high reset
//   cfg_wr, cfg_timer_en,
//   cfg_div_en, cfg_div_val : software config write strobe and payload
//   cfg_busy              : write pending (DRAIN or APPLY)
//   cfg_done              : one-cycle pulse, new config is on the outputs
//   cfg_err               : one-cycle pulse, a write was dropped while busy
//   dbg_halt_req          : level debug halt request
//   dbg_halt_ack          : prescaler is frozen
//   cnt_en                : prescaler period-boundary tick
//   timer_en, halt_req,
//   div_en, div_val       : prescaler control outputs
// ---------------------------------------------------------------------------
module timer_cfg_sequencer
  import timer_pkg::*;
#(
  parameter int MAX_DIV = MAX_DIV_DEFAULT,
  parameter int TO_W    = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_wr,
  input  logic             cfg_timer_en,
  input  logic             cfg_div_en,
  input  logic [DIV_W-1:0] cfg_div_val,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic             dbg_halt_req,
  output logic             dbg_halt_ack,
  input  logic             cnt_en,
  output logic             timer_en,
  output logic             halt_req,
  output logic             div_en,
  output logic [DIV_W-1:0] div_val
);

  localparam logic [DIV_W-1:0] MAX_DIV_V = DIV_W'(MAX_DIV);

  seq_state_t       state;
  logic             shd_timer_en;
  logic             shd_div_en;
  logic [DIV_W-1:0] shd_div_val;

  logic [DIV_W-1:0] div_clamped;
  logic             needs_drain;
  logic             wdog_load;
  logic             wdog_run;
  logic             wdog_expire;

  // A write only has to wait for a tick when it would change the period of
  // a timer that is actually counting. Turning the timer off, or writing
  // alongside a halt request (the prescaler is about to freeze), is applied
  // straight away.
  always_comb begin
    div_clamped = clamp_div(cfg_div_val, MAX_DIV_V);
    needs_drain = timer_en && div_en && cfg_timer_en && !dbg_halt_req &&
                  ((cfg_div_en != div_en) || (div_clamped != div_val));
    wdog_load   = (state == IDLE) && cfg_wr && needs_drain;
    wdog_run    = (state == DRAIN);
  end

  timer_drain_wdog #(
    .TO_W (TO_W)
  ) u_wdog (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (wdog_load),
    .load_exp (div_val),
    .run      (wdog_run),
    .expire   (wdog_expire)
  );

  // Sequencer FSM with shadow registers and registered outputs. The watchdog
  // is loaded from the currently applied exponent on the same edge that
  // enters DRAIN. The halt ack always trails halt_req by one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      shd_timer_en <= 1'b0;
      shd_div_en   <= 1'b0;
      shd_div_val  <= '0;
      timer_en     <= 1'b0;
      div_en       <= 1'b0;
      div_val      <= '0;
      halt_req     <= 1'b0;
      dbg_halt_ack <= 1'b0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_wr) begin
            shd_timer_en <= cfg_timer_en;
            shd_div_en   <= cfg_div_en;
            shd_div_val  <= div_clamped;
            cfg_busy     <= 1'b1;
            state        <= needs_drain ? DRAIN : APPLY;
          end else if (dbg_halt_req) begin
            halt_req <= 1'b1;
            state    <= HALT;
          end
        end
        DRAIN: begin
          if (cfg_wr) begin
            cfg_err <= 1'b1;
          end
          if (dbg_halt_req || cnt_en || wdog_expire) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          if (cfg_wr) begin
            cfg_err <= 1'b1;
          end
          timer_en <= shd_timer_en;
          div_en   <= shd_div_en;
          div_val  <= shd_div_val;
          cfg_done <= 1'b1;
          cfg_busy <= 1'b0;
          if (dbg_halt_req) begin
            halt_req     <= 1'b1;
            dbg_halt_ack <= halt_req;
            state        <= HALT;
          end else begin
            halt_req     <= 1'b0;
            dbg_halt_ack <= 1'b0;
            state        <= IDLE;
          end
        end
        HALT: begin
          if (cfg_wr) begin
            shd_timer_en <= cfg_timer_en;
            shd_div_en   <= cfg_div_en;
            shd_div_val  <= div_clamped;
            cfg_busy     <= 1'b1;
            dbg_halt_ack <= halt_req;
            state        <= APPLY;
          end else if (!dbg_halt_req) begin
            halt_req     <= 1'b0;
            dbg_halt_ack <= 1'b0;
            state        <= IDLE;
          end else begin
            dbg_halt_ack <= halt_req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timer_cfg_sequencer
// Directed, self-checking bench for timer_cfg_sequencer. Each applyStimulus
// call drives one cycle of inputs and returns 1ns after the sampling edge,
// where checkOutput compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_timer_cfg_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       cfg_wr;
  logic       cfg_timer_en;
  logic       cfg_div_en;
  logic [3:0] cfg_div_val;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;
  logic       dbg_halt_req;
  logic       dbg_halt_ack;
  logic       cnt_en;
  logic       timer_en;
  logic       halt_req;
  logic       div_en;
  logic [3:0] div_val;

  int checks   = 0;
  int failures = 0;

  timer_cfg_sequencer dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cfg_wr       (cfg_wr),
    .cfg_timer_en (cfg_timer_en),
    .cfg_div_en   (cfg_div_en),
    .cfg_div_val  (cfg_div_val),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .dbg_halt_req (dbg_halt_req),
    .dbg_halt_ack (dbg_halt_ack),
    .cnt_en       (cnt_en),
    .timer_en     (timer_en),
    .halt_req     (halt_req),
    .div_en       (div_en),
    .div_val      (div_val)
  );

  // Free-running 10ns clock.
  always #5 sys_clk = ~sys_clk;

  // Drive one cycle of inputs and return just after the edge that samples them.
  task automatic applyStimulus(input logic wr, input logic ten, input logic den,
                               input logic [3:0] dval, input logic halt,
                               input logic tick);
    cfg_wr       = wr;
    cfg_timer_en = ten;
    cfg_div_en   = den;
    cfg_div_val  = dval;
    dbg_halt_req = halt;
    cnt_en       = tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Compare one observed output against its expected value.
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed test sequence.
  initial begin
    sys_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("rst_timer_en", 4'(timer_en), 4'd0);
    checkOutput("rst_div_en", 4'(div_en), 4'd0);
    checkOutput("rst_div_val", div_val, 4'd0);
    checkOutput("rst_halt_req", 4'(halt_req), 4'd0);
    checkOutput("rst_ack", 4'(dbg_halt_ack), 4'd0);
    checkOutput("rst_busy", 4'(cfg_busy), 4'd0);
    checkOutput("rst_done", 4'(cfg_done), 4'd0);
    checkOutput("rst_err", 4'(cfg_err), 4'd0);
    sys_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // 1: immediate write from an idle, stopped timer
    $display("[TB] step 1: immediate write");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    checkOutput("t1_busy_n1", 4'(cfg_busy), 4'd1);
    checkOutput("t1_timer_en_n1", 4'(timer_en), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t1_timer_en_n2", 4'(timer_en), 4'd1);
    checkOutput("t1_div_en_n2", 4'(div_en), 4'd1);
    checkOutput("t1_div_val_n2", div_val, 4'd2);
    checkOutput("t1_done_n2", 4'(cfg_done), 4'd1);
    checkOutput("t1_busy_n2", 4'(cfg_busy), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t1_done_n3", 4'(cfg_done), 4'd0);

    // 2: deferred divisor change released by a prescaler tick
    $display("[TB] step 2: drain until tick");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    checkOutput("t2_busy_drain", 4'(cfg_busy), 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0);
    checkOutput("t2_err_pulse", 4'(cfg_err), 4'd1);
    checkOutput("t2_div_val_held", div_val, 4'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("t2_err_clear", 4'(cfg_err), 4'd0);
    checkOutput("t2_div_val_tick1", div_val, 4'd2);
    checkOutput("t2_busy_apply", 4'(cfg_busy), 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t2_div_val_tick2", div_val, 4'd4);
    checkOutput("t2_done", 4'(cfg_done), 4'd1);
    checkOutput("t2_busy_end", 4'(cfg_busy), 4'd0);

    // 3: timer off is immediate; then watchdog-forced apply at div 3
    $display("[TB] step 3: watchdog");
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_timer_off", 4'(timer_en), 4'd0);
    checkOutput("t3_off_done", 4'(cfg_done), 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_timer_on", 4'(timer_en), 4'd1);
    checkOutput("t3_div3", div_val, 4'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    checkOutput("t3_busy_wait", 4'(cfg_busy), 4'd1);
    checkOutput("t3_done_wait", 4'(cfg_done), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_div_before", div_val, 4'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t3_div_after", div_val, 4'd1);
    checkOutput("t3_done", 4'(cfg_done), 4'd1);

    // 4: halt from idle, clamped write while halted, release
    $display("[TB] step 4: halt handshake");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t4_halt_req_p1", 4'(halt_req), 4'd1);
    checkOutput("t4_ack_p1", 4'(dbg_halt_ack), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t4_ack_p2", 4'(dbg_halt_ack), 4'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0);
    checkOutput("t4_wr_busy", 4'(cfg_busy), 4'd1);
    checkOutput("t4_wr_ack", 4'(dbg_halt_ack), 4'd1);
    checkOutput("t4_wr_halt_req", 4'(halt_req), 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t4_div_clamped", div_val, 4'd8);
    checkOutput("t4_done", 4'(cfg_done), 4'd1);
    checkOutput("t4_ack_hold", 4'(dbg_halt_ack), 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t4_rel_halt_req", 4'(halt_req), 4'd0);
    checkOutput("t4_rel_ack", 4'(dbg_halt_ack), 4'd0);

    // 5: halt request during drain forces apply then halt
    $display("[TB] step 5: halt mid-drain");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);
    checkOutput("t5_busy", 4'(cfg_busy), 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t5_div_apply", div_val, 4'd8);
    checkOutput("t5_halt_req_apply", 4'(halt_req), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t5_div_new", div_val, 4'd2);
    checkOutput("t5_done", 4'(cfg_done), 4'd1);
    checkOutput("t5_halt_req", 4'(halt_req), 4'd1);
    checkOutput("t5_ack_early", 4'(dbg_halt_ack), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("t5_ack", 4'(dbg_halt_ack), 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t5_rel_ack", 4'(dbg_halt_ack), 4'd0);

    // 6: reset while a 4->7 change is draining
    $display("[TB] step 6: reset mid-drain");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t6_div4", div_val, 4'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    checkOutput("t6_busy_drain", 4'(cfg_busy), 4'd1);
    sys_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    sys_rst = 1'b0;
    checkOutput("t6_rst_div_val", div_val, 4'd0);
    checkOutput("t6_rst_timer_en", 4'(timer_en), 4'd0);
    checkOutput("t6_rst_div_en", 4'(div_en), 4'd0);
    checkOutput("t6_rst_busy", 4'(cfg_busy), 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    checkOutput("t6_no_done", 4'(cfg_done), 4'd0);
    checkOutput("t6_div_stays0", div_val, 4'd0);
    checkOutput("t6_timer_stays0", 4'(timer_en), 4'd0);
    checkOutput("t6_idle", 4'(cfg_busy), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
